instr_sequencer: RTL and testbench

Fetch/decode/execute controller for the 32-entry instruction ROM.
- Owns the program counter and drives the ROM address.
- Latches each instruction word (4-bit opcode + 2-bit register field) into an instruction register.
- Resolves HALT, JMP and BZ itself; hands every other opcode to the datapath with a start/done handshake.

---
 rtl/instr_sequencer.sv | 123 ++++++++++++
 tb/tb_instr_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 32-entry instruction ROM.
// Owns the PC, latches the instruction register, resolves HALT/JMP/BZ and hands other opcodes to the datapath.
module instr_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned REG_WIDTH    = 2,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OP = 4'b1111,
  parameter logic [OPCODE_WIDTH-1:0] JMP_OP  = 4'b1110,
  parameter logic [OPCODE_WIDTH-1:0] BZ_OP   = 4'b1101
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              run,
  output logic [ADDR_WIDTH-1:0]             rom_addr,
  input  logic [OPCODE_WIDTH+REG_WIDTH-1:0] rom_data,
  output logic [OPCODE_WIDTH-1:0]           opcode,
  output logic [REG_WIDTH-1:0]              reg_sel,
  output logic                              exec_start,
  input  logic                              exec_done,
  input  logic [ADDR_WIDTH-1:0]             jmp_target,
  input  logic                              zero_flag,
  output logic                              busy,
  output logic                              halted
);

  localparam int unsigned INSTR_WIDTH = OPCODE_WIDTH + REG_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_WAIT   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t                   state, state_nxt;
  logic [ADDR_WIDTH-1:0]    pc, pc_nxt;
  logic [INSTR_WIDTH-1:0]   ir, ir_nxt;
  logic [OPCODE_WIDTH-1:0]  ir_op;
  logic                     ir_is_ctrl;

  assign ir_op      = ir[INSTR_WIDTH-1:REG_WIDTH];
  assign ir_is_ctrl = (ir_op == HALT_OP) || (ir_op == JMP_OP) || (ir_op == BZ_OP);

  // State, PC and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  // Next-state, PC and IR update
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        ir_nxt    = rom_data;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (ir_op == HALT_OP) begin
          state_nxt = S_HALT;
        end else if (ir_op == JMP_OP) begin
          pc_nxt    = jmp_target;
          state_nxt = S_FETCH;
        end else if (ir_op == BZ_OP) begin
          pc_nxt    = zero_flag ? jmp_target : pc + ADDR_WIDTH'(1);
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (exec_done) begin
          pc_nxt    = pc + ADDR_WIDTH'(1);
          state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        // Leaving HALT rewinds so the next run restarts from address 0
        if (!run) begin
          pc_nxt    = '0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from state, PC and IR
  always_comb begin
    rom_addr   = pc;
    opcode     = ir_op;
    reg_sel    = ir[REG_WIDTH-1:0];
    exec_start = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH:  busy = 1'b1;
      S_DECODE: begin
        busy       = 1'b1;
        exec_start = !ir_is_ctrl;
      end
      S_WAIT:   busy = 1'b1;
      S_HALT:   halted = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: ROM and datapath modelled here, PC tracked by an instruction-level reference model.
module tb_instr_sequencer;

  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [3:0] OP_JMP  = 4'b1110;
  localparam logic [3:0] OP_BZ   = 4'b1101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       exec_done = 1'b0;
  logic       zero_flag = 1'b0;
  logic [4:0] jmp_target = '0;
  logic [4:0] rom_addr;
  logic [5:0] rom_data;
  logic [3:0] opcode;
  logic [1:0] reg_sel;
  logic       exec_start, busy, halted;

  logic [5:0] rom [32];
  logic [4:0] mpc;
  int vectors = 0;
  int miscompares = 0;

  assign rom_data = rom[rom_addr];

  instr_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .opcode     (opcode),
    .reg_sel    (reg_sel),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .jmp_target (jmp_target),
    .zero_flag  (zero_flag),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [5:0] normal_word();
    logic [3:0] op;
    op = 4'($urandom_range(0, 12));
    return {op, 2'($urandom_range(0, 3))};
  endfunction

  function automatic logic [4:0] next_seq(input logic [4:0] p);
    return 5'((int'(p) + 1) % 32);
  endfunction

  // One instruction from its FETCH cycle; called at a negedge with the DUT in FETCH.
  task automatic run_instr(input int d, input logic zf, input logic [4:0] tgt, output logic hit_halt);
    logic [5:0] w;
    logic [3:0] op;
    logic       exp_start;
    w = rom[mpc];
    op = w[5:2];
    hit_halt = 1'b0;
    vectors++;
    if ({rom_addr, busy, halted, exec_start} !== {mpc, 3'b100}) begin
      miscompares++;
      $display("FAIL fetch: got addr=%0d busy/halt/start=%b%b%b, want addr=%0d 100",
               rom_addr, busy, halted, exec_start, mpc);
    end
    exec_done  = 1'($urandom_range(0, 1));
    run        = 1'($urandom_range(0, 1));
    zero_flag  = 1'($urandom_range(0, 1));
    jmp_target = 5'($urandom_range(0, 31));
    tick();
    exp_start = !(op == OP_HALT || op == OP_JMP || op == OP_BZ);
    vectors++;
    if ({opcode, reg_sel, rom_addr, busy, halted, exec_start} !== {w, mpc, 2'b10, exp_start}) begin
      miscompares++;
      $display("FAIL decode@%0d: got op=%h rs=%0d addr=%0d b/h/s=%b%b%b, want op=%h rs=%0d addr=%0d b/h/s=10%b",
               mpc, opcode, reg_sel, rom_addr, busy, halted, exec_start, w[5:2], w[1:0], mpc, exp_start);
    end
    zero_flag  = zf;
    jmp_target = tgt;
    exec_done  = 1'($urandom_range(0, 1));
    if (op == OP_HALT) begin
      tick();
      hit_halt = 1'b1;
      vectors++;
      if ({rom_addr, busy, halted, exec_start} !== {mpc, 3'b010}) begin
        miscompares++;
        $display("FAIL halt_entry: got addr=%0d b/h/s=%b%b%b, want addr=%0d 010",
                 rom_addr, busy, halted, exec_start, mpc);
      end
    end else if (op == OP_JMP) begin
      mpc = tgt;
      tick();
    end else if (op == OP_BZ) begin
      mpc = zf ? tgt : next_seq(mpc);
      tick();
    end else begin
      tick();
      for (int i = 0; i <= d; i++) begin
        vectors++;
        if ({opcode, reg_sel, rom_addr, busy, halted, exec_start} !== {w, mpc, 3'b100}) begin
          miscompares++;
          $display("FAIL wait@%0d cyc%0d: got op=%h rs=%0d addr=%0d b/h/s=%b%b%b, want op=%h rs=%0d addr=%0d 100",
                   mpc, i, opcode, reg_sel, rom_addr, busy, halted, exec_start, w[5:2], w[1:0], mpc);
        end
        zero_flag  = 1'($urandom_range(0, 1));
        jmp_target = 5'($urandom_range(0, 31));
        exec_done  = (i == d);
        tick();
      end
      exec_done = 1'b0;
      mpc = next_seq(mpc);
    end
  endtask

  // Called at a negedge in HALT: hold run high, drop it, then restart.
  task automatic halt_restart(input int hold);
    run = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      vectors++;
      if ({rom_addr, busy, halted, exec_start} !== {mpc, 3'b010}) begin
        miscompares++;
        $display("FAIL halt_hold: got addr=%0d b/h/s=%b%b%b, want addr=%0d 010",
                 rom_addr, busy, halted, exec_start, mpc);
      end
    end
    run = 1'b0;
    tick();
    vectors++;
    if ({rom_addr, busy, halted, exec_start} !== 8'h00) begin
      miscompares++;
      $display("FAIL halt_exit: got addr=%0d b/h/s=%b%b%b, want addr=0 000",
               rom_addr, busy, halted, exec_start);
    end
    run = 1'b1;
    tick();
    mpc = 5'd0;
  endtask

  task automatic test_reset;
    logic h;
    rst_n = 1'b0;
    run = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rom_addr, opcode, reg_sel, busy, halted, exec_start} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset: got addr=%0d op=%h rs=%0d b/h/s=%b%b%b, want all 0",
               rom_addr, opcode, reg_sel, busy, halted, exec_start);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({rom_addr, busy, halted, exec_start} !== 8'h00) begin
      miscompares++;
      $display("FAIL idle: got addr=%0d b/h/s=%b%b%b, want 0 000", rom_addr, busy, halted, exec_start);
    end
    run = 1'b1;
    tick();
    mpc = 5'd0;
    run_instr(0, 1'b0, 5'd0, h);
  endtask

  task automatic test_straight;
    logic h;
    for (int i = 1; i < 4; i++) run_instr(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), h);
  endtask

  task automatic test_branch;
    logic h;
    run_instr(0, 1'b0, 5'd20, h);
    run_instr(0, 1'b1, 5'd3, h);
    run_instr(1, 1'b0, 5'd0, h);
    run_instr(0, 1'b1, 5'd20, h);
    run_instr(0, 1'b0, 5'($urandom_range(0, 31)), h);
    run_instr(2, 1'b0, 5'd0, h);
    run_instr(0, 1'b1, 5'd5, h);
    run_instr(0, 1'b0, 5'd0, h);
    run_instr(0, 1'b0, 5'd0, h);
    run_instr(0, 1'b0, 5'd0, h);
    vectors++;
    if (h !== 1'b1 || mpc !== 5'd7) begin
      miscompares++;
      $display("FAIL branch_path: got halt=%b at model pc=%0d, want halt=1 at 7", h, mpc);
    end
  endtask

  task automatic test_halt;
    rom[0] = {OP_JMP, 2'b00};
    halt_restart(3);
  endtask

  task automatic test_wrap;
    logic h;
    run_instr(0, 1'b0, 5'd31, h);
    run_instr(5, 1'b0, 5'd0, h);
    rom[0] = {OP_JMP, 2'b01};
    run_instr(0, 1'b0, 5'd12, h);
  endtask

  task automatic test_reset_mid;
    run = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rom_addr, opcode, reg_sel, busy, halted, exec_start} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got addr=%0d op=%h rs=%0d b/h/s=%b%b%b, want all 0",
               rom_addr, opcode, reg_sel, busy, halted, exec_start);
    end
    exec_done = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({rom_addr, busy, halted, exec_start} !== 8'h00) begin
        miscompares++;
        $display("FAIL late_done%0d: got addr=%0d b/h/s=%b%b%b, want 0 000",
                 i, rom_addr, busy, halted, exec_start);
      end
    end
    exec_done = 1'b0;
  endtask

  task automatic test_random;
    logic h;
    for (int a = 0; a < 32; a++) rom[a] = 6'($urandom_range(0, 63));
    run = 1'b1;
    tick();
    mpc = 5'd0;
    for (int n = 0; n < 150; n++) begin
      run_instr(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), h);
      if (h) halt_restart(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    for (int a = 0; a < 32; a++) rom[a] = normal_word();
    rom[0]  = 6'b000000;
    rom[4]  = {OP_JMP, 2'b10};
    rom[20] = {OP_BZ, 2'b01};
    rom[22] = {OP_JMP, 2'b11};
    rom[7]  = {OP_HALT, 2'b00};
    test_reset();
    test_straight();
    test_branch();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
